rx_phase_sync: RTL and testbench

//   Receive-side symbol timing stage; sits downstream of the tx polyphase pulse-shaping filter (after channel/matched filter).

---
 rtl/rx_phase_sync_pkg.sv | 20 ++
 rtl/rx_phase_sync.sv | 148 ++++++++++++++
 tb/tb_rx_phase_sync.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_phase_sync_pkg.sv
// Purpose : shared types and default parameters for the receive symbol-timing stage.
// Latency : n/a (package only).
// Backpressure: n/a.
package rx_phase_sync_pkg;

   localparam int UPSAMPLE_DEF      = 4;   // samples per symbol, matches tx polyphase filter
   localparam int IN_NBITS_DEF      = 8;   // S(8,7) sample format from tx
   localparam int IN_FBITS_DEF      = 7;
   localparam int ACC_LOG2_SYMS_DEF = 10;  // estimation window = 2^10 symbols

   typedef enum logic {
      ST_ACCUM  = 1'b0,
      ST_DECIDE = 1'b1
   } state_t;

   function automatic bit is_pow2(input int n);
      return (n > 1) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/rx_phase_sync.sv
// Purpose : picks the sampling phase with the largest mean |x| over a symbol window, decimates and slices to bits.
// Latency : 1 clk from the selected-phase sample (enable=1) to rx_valid/rx_bit.
// Backpressure: none; one sample accepted on every enable cycle, nothing is ever dropped.
// Ports   : clk, rst (async, active-high); enable/rx_in sample strobe and data;
//           phase_override_en/phase_override force the decimation phase;
//           rx_bit/rx_valid sliced symbol; phase_sel phase in use; lock set after first window.
module rx_phase_sync
   import rx_phase_sync_pkg::*;
#(
   parameter int UPSAMPLE      = UPSAMPLE_DEF,
   parameter int IN_NBITS      = IN_NBITS_DEF,
   parameter int IN_FBITS      = IN_FBITS_DEF,
   parameter int ACC_LOG2_SYMS = ACC_LOG2_SYMS_DEF,
   localparam int PH_NBITS     = $clog2(UPSAMPLE),
   localparam int ACC_NBITS    = IN_NBITS + ACC_LOG2_SYMS
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enable,
   input  logic signed [IN_NBITS-1:0] rx_in,
   input  logic                       phase_override_en,
   input  logic [PH_NBITS-1:0]        phase_override,
   output logic                       rx_bit,
   output logic                       rx_valid,
   output logic [PH_NBITS-1:0]        phase_sel,
   output logic                       lock
);

   // Phase counter wraps by natural overflow, so UPSAMPLE must be a power of two.
   if (!is_pow2(UPSAMPLE) || (IN_FBITS >= IN_NBITS)) begin : g_bad_params
      $error("rx_phase_sync: UPSAMPLE must be a power of two and IN_FBITS < IN_NBITS");
   end

   typedef logic [ACC_NBITS-1:0] acc_t;

   localparam logic signed [IN_NBITS-1:0] IN_MIN  = {1'b1, {(IN_NBITS-1){1'b0}}};
   localparam logic [IN_NBITS-1:0]        MAG_MAX = {1'b0, {(IN_NBITS-1){1'b1}}};
   localparam logic [PH_NBITS-1:0]        PH_LAST = PH_NBITS'(UPSAMPLE - 1);

   state_t                   state_q, state_d;
   logic [PH_NBITS-1:0]      ph_q, ph_d;
   logic [ACC_LOG2_SYMS-1:0] sym_cnt_q, sym_cnt_d;
   acc_t                     acc_q [UPSAMPLE];
   acc_t                     acc_d [UPSAMPLE];
   logic [PH_NBITS-1:0]      est_q, est_d;
   logic                     lock_q, lock_d;
   logic                     rx_bit_q, rx_bit_d;
   logic                     rx_valid_q, rx_valid_d;

   logic [IN_NBITS-1:0]      mag;
   acc_t                     mag_ext;

   // Ties resolve to the lowest index because only a strictly larger value replaces the best.
   function automatic logic [PH_NBITS-1:0] argmax(input acc_t a [UPSAMPLE]);
      logic [PH_NBITS-1:0] idx;
      acc_t                best;
      idx  = '0;
      best = a[0];
      for (int i = 1; i < UPSAMPLE; i++) begin
         if (a[i] > best) begin
            best = a[i];
            idx  = PH_NBITS'(i);
         end
      end
      return idx;
   endfunction

   // |x| with the most negative code saturated so the magnitude fits IN_NBITS-1 bits.
   always_comb begin
      if (rx_in == IN_MIN) begin
         mag = MAG_MAX;
      end else if (rx_in[IN_NBITS-1]) begin
         mag = $unsigned(-rx_in);
      end else begin
         mag = $unsigned(rx_in);
      end
   end

   assign mag_ext   = acc_t'(mag);
   assign phase_sel = phase_override_en ? phase_override : est_q;

   always_comb begin
      state_d    = state_q;
      ph_d       = ph_q;
      sym_cnt_d  = sym_cnt_q;
      acc_d      = acc_q;
      est_d      = est_q;
      lock_d     = lock_q;
      rx_bit_d   = rx_bit_q;
      rx_valid_d = 1'b0;

      if (state_q == ST_DECIDE) begin
         est_d   = argmax(acc_q);
         lock_d  = 1'b1;
         state_d = ST_ACCUM;
         for (int i = 0; i < UPSAMPLE; i++) begin
            acc_d[i] = '0;
         end
      end

      if (enable) begin
         ph_d = ph_q + PH_NBITS'(1);
         // acc_d is already cleared in DECIDE, so a DECIDE-cycle sample starts the new window.
         acc_d[ph_q] = acc_d[ph_q] + mag_ext;
         if (ph_q == PH_LAST) begin
            sym_cnt_d = sym_cnt_q + ACC_LOG2_SYMS'(1);
            if ((state_q == ST_ACCUM) && (sym_cnt_q == '1)) begin
               state_d = ST_DECIDE;
            end
         end
         if (ph_q == phase_sel) begin
            rx_valid_d = 1'b1;
            rx_bit_d   = ~rx_in[IN_NBITS-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_ACCUM;
         ph_q       <= '0;
         sym_cnt_q  <= '0;
         est_q      <= '0;
         lock_q     <= 1'b0;
         rx_bit_q   <= 1'b0;
         rx_valid_q <= 1'b0;
         for (int i = 0; i < UPSAMPLE; i++) begin
            acc_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         ph_q       <= ph_d;
         sym_cnt_q  <= sym_cnt_d;
         est_q      <= est_d;
         lock_q     <= lock_d;
         rx_bit_q   <= rx_bit_d;
         rx_valid_q <= rx_valid_d;
         for (int i = 0; i < UPSAMPLE; i++) begin
            acc_q[i] <= acc_d[i];
         end
      end
   end

   assign rx_bit   = rx_bit_q;
   assign rx_valid = rx_valid_q;
   assign lock     = lock_q;

endmodule

// File: tb/tb_rx_phase_sync.sv
// Purpose : directed bench for rx_phase_sync with a 16-symbol estimation window.
// Latency : outputs are observed 1 time unit after the capturing clock edge.
// Backpressure: n/a.
module tb_rx_phase_sync;

   logic              clk = 1'b0;
   logic              rst;
   logic              enable;
   logic signed [7:0] rx_in;
   logic              phase_override_en;
   logic [1:0]        phase_override;
   logic              rx_bit;
   logic              rx_valid;
   logic [1:0]        phase_sel;
   logic              lock;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] pat = 16'b1010_0110_1101_0011;

   always #5 clk = ~clk;

   rx_phase_sync #(
      .UPSAMPLE      (4),
      .IN_NBITS      (8),
      .IN_FBITS      (7),
      .ACC_LOG2_SYMS (4)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .enable            (enable),
      .rx_in             (rx_in),
      .phase_override_en (phase_override_en),
      .phase_override    (phase_override),
      .rx_bit            (rx_bit),
      .rx_valid          (rx_valid),
      .phase_sel         (phase_sel),
      .lock              (lock)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drive one cycle's inputs at the falling edge, then observe just after the rising edge.
   task automatic step(input logic en, input logic signed [7:0] x);
      @(negedge clk);
      enable = en;
      rx_in  = x;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst    = 1'b1;
      enable = 1'b0;
      rx_in  = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Shaped pulse: peak at phase 2, sign carries the symbol bit.
   function automatic logic signed [7:0] tx_samp(input int p, input logic b);
      logic signed [7:0] r;
      case (p)
         0:       r = 8'sd20;
         1:       r = 8'sd60;
         2:       r = 8'sd110;
         default: r = 8'sd60;
      endcase
      if (!b) r = -r;
      return r;
   endfunction

   task automatic test_power_on();
      rst = 1'b1; enable = 1'b0; rx_in = '0;
      phase_override_en = 1'b0; phase_override = '0;
      @(negedge clk);
      @(negedge clk);
      n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL por_valid: got %b want 0", rx_valid); end
      n_checks++; if (rx_bit !== 1'b0) begin n_fail++; $display("FAIL por_bit: got %b want 0", rx_bit); end
      n_checks++; if (phase_sel !== 2'd0) begin n_fail++; $display("FAIL por_phase: got %0d want 0", phase_sel); end
      n_checks++; if (lock !== 1'b0) begin n_fail++; $display("FAIL por_lock: got %b want 0", lock); end
      rst = 1'b0;
   endtask

   task automatic test_tx_model();
      logic b;
      apply_reset();
      for (int s = 0; s < 16; s++) begin
         b = pat[s];
         for (int p = 0; p < 4; p++) begin
            step(1'b1, tx_samp(p, b));
            n_checks++; if (rx_valid !== (p == 0)) begin n_fail++; $display("FAIL tx_prelock_valid s%0d p%0d: got %b want %b", s, p, rx_valid, (p == 0)); end
            if (p == 0) begin
               n_checks++; if (rx_bit !== b) begin n_fail++; $display("FAIL tx_prelock_bit s%0d: got %b want %b", s, rx_bit, b); end
            end
         end
      end
      n_checks++; if (lock !== 1'b0) begin n_fail++; $display("FAIL tx_lock_early: got %b want 0", lock); end
      step(1'b0, 8'sd0);
      n_checks++; if (lock !== 1'b1) begin n_fail++; $display("FAIL tx_lock: got %b want 1", lock); end
      n_checks++; if (phase_sel !== 2'd2) begin n_fail++; $display("FAIL tx_phase: got %0d want 2", phase_sel); end
      for (int s = 0; s < 8; s++) begin
         b = pat[s];
         for (int p = 0; p < 4; p++) begin
            step(1'b1, tx_samp(p, b));
            n_checks++; if (rx_valid !== (p == 2)) begin n_fail++; $display("FAIL tx_valid s%0d p%0d: got %b want %b", s, p, rx_valid, (p == 2)); end
            if (p == 2) begin
               n_checks++; if (rx_bit !== b) begin n_fail++; $display("FAIL tx_bit s%0d: got %b want %b", s, rx_bit, b); end
            end
         end
      end
   endtask

   task automatic test_reset();
      step(1'b1, 8'sd20);
      step(1'b1, 8'sd60);
      step(1'b1, 8'sd110);
      n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid: got %b want 1", rx_valid); end
      n_checks++; if (lock !== 1'b1) begin n_fail++; $display("FAIL rst_pre_lock: got %b want 1", lock); end
      #2;
      rst = 1'b1;
      #1;
      n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", rx_valid); end
      n_checks++; if (rx_bit !== 1'b0) begin n_fail++; $display("FAIL rst_bit: got %b want 0", rx_bit); end
      n_checks++; if (phase_sel !== 2'd0) begin n_fail++; $display("FAIL rst_phase: got %0d want 0", phase_sel); end
      n_checks++; if (lock !== 1'b0) begin n_fail++; $display("FAIL rst_lock: got %b want 0", lock); end
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 8'sd50);
         n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_hold_valid c%0d: got %b want 0", i, rx_valid); end
      end
      @(negedge clk);
      rst = 1'b0; enable = 1'b0;
   endtask

   // Window A and B: -128 on phase 3; window C: constant 64 on every phase.
   task automatic test_saturate_and_tie();
      logic signed [7:0] x;
      apply_reset();
      for (int w = 0; w < 2; w++) begin
         for (int s = 0; s < 16; s++) begin
            for (int p = 0; p < 4; p++) begin
               x = (p == 3) ? -8'sd128 : 8'sd0;
               step(1'b1, x);
               if (w == 1) begin
                  n_checks++; if (rx_valid !== (p == 3)) begin n_fail++; $display("FAIL sat_valid s%0d p%0d: got %b want %b", s, p, rx_valid, (p == 3)); end
                  if (p == 3) begin
                     n_checks++; if (rx_bit !== 1'b0) begin n_fail++; $display("FAIL sat_bit s%0d: got %b want 0", s, rx_bit); end
                  end
               end
            end
         end
         step(1'b0, 8'sd0);
         n_checks++; if (phase_sel !== 2'd3) begin n_fail++; $display("FAIL sat_phase w%0d: got %0d want 3", w, phase_sel); end
         n_checks++; if (lock !== 1'b1) begin n_fail++; $display("FAIL sat_lock w%0d: got %b want 1", w, lock); end
      end
      for (int s = 0; s < 16; s++) begin
         for (int p = 0; p < 4; p++) begin
            step(1'b1, 8'sd64);
         end
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (dut.acc_q[i] !== 12'd1024) begin n_fail++; $display("FAIL tie_acc%0d: got %0d want 1024", i, dut.acc_q[i]); end
      end
      step(1'b0, 8'sd0);
      n_checks++; if (phase_sel !== 2'd0) begin n_fail++; $display("FAIL tie_phase: got %0d want 0", phase_sel); end
      n_checks++; if (dut.acc_q[0] !== 12'd0) begin n_fail++; $display("FAIL tie_clear: got %0d want 0", dut.acc_q[0]); end
   endtask

   task automatic test_override();
      logic b;
      logic signed [7:0] x;
      apply_reset();
      phase_override_en = 1'b1;
      phase_override    = 2'd1;
      #1;
      n_checks++; if (phase_sel !== 2'd1) begin n_fail++; $display("FAIL ovr_phase_pre: got %0d want 1", phase_sel); end
      for (int s = 0; s < 16; s++) begin
         b = pat[s];
         for (int p = 0; p < 4; p++) begin
            case (p)
               0:       x = 8'sd50;
               1:       x = b ? 8'sd40 : -8'sd40;
               2:       x = 8'sd10;
               default: x = -8'sd100;
            endcase
            step(1'b1, x);
            n_checks++; if (rx_valid !== (p == 1)) begin n_fail++; $display("FAIL ovr_valid s%0d p%0d: got %b want %b", s, p, rx_valid, (p == 1)); end
            if (p == 1) begin
               n_checks++; if (rx_bit !== b) begin n_fail++; $display("FAIL ovr_bit s%0d: got %b want %b", s, rx_bit, b); end
            end
         end
         n_checks++; if (lock !== 1'b0) begin n_fail++; $display("FAIL ovr_lock_early s%0d: got %b want 0", s, lock); end
      end
      step(1'b0, 8'sd0);
      n_checks++; if (lock !== 1'b1) begin n_fail++; $display("FAIL ovr_lock: got %b want 1", lock); end
      n_checks++; if (phase_sel !== 2'd1) begin n_fail++; $display("FAIL ovr_phase_held: got %0d want 1", phase_sel); end
      phase_override_en = 1'b0;
      #1;
      n_checks++; if (phase_sel !== 2'd3) begin n_fail++; $display("FAIL ovr_release: got %0d want 3", phase_sel); end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      for (int s = 0; s < 16; s++) begin
         step(1'b1, 8'sd20);
         step(1'b1, 8'sd90);
         step(1'b1, 8'sd30);
         step(1'b1, 8'sd20);
      end
      // DECIDE cycle with a live sample on phase 0.
      step(1'b1, -8'sd77);
      n_checks++; if (lock !== 1'b1) begin n_fail++; $display("FAIL b2b_lock: got %b want 1", lock); end
      n_checks++; if (phase_sel !== 2'd1) begin n_fail++; $display("FAIL b2b_phase: got %0d want 1", phase_sel); end
      n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", rx_valid); end
      n_checks++; if (rx_bit !== 1'b0) begin n_fail++; $display("FAIL b2b_bit: got %b want 0", rx_bit); end
      n_checks++; if (dut.acc_q[0] !== 12'd77) begin n_fail++; $display("FAIL b2b_acc0: got %0d want 77", dut.acc_q[0]); end
      n_checks++; if (dut.acc_q[1] !== 12'd0) begin n_fail++; $display("FAIL b2b_acc1: got %0d want 0", dut.acc_q[1]); end
      step(1'b1, 8'sd90);
      n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_newph_valid: got %b want 1", rx_valid); end
      step(1'b1, 8'sd30);
      step(1'b1, 8'sd20);
      for (int s = 1; s < 9; s++) begin
         step(1'b1, 8'sd20);
         step(1'b1, 8'sd90);
         step(1'b1, 8'sd30);
         step(1'b1, 8'sd20);
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++; if (lock !== 1'b0) begin n_fail++; $display("FAIL b2b_rst_lock: got %b want 0", lock); end
      n_checks++; if (phase_sel !== 2'd0) begin n_fail++; $display("FAIL b2b_rst_phase: got %0d want 0", phase_sel); end
      @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int s = 0; s < 16; s++) begin
         step(1'b1, 8'sd10);
         step(1'b1, 8'sd20);
         step(1'b1, 8'sd100);
         step(1'b1, 8'sd20);
         n_checks++; if (lock !== 1'b0) begin n_fail++; $display("FAIL b2b_relock_early s%0d: got %b want 0", s, lock); end
      end
      step(1'b0, 8'sd0);
      n_checks++; if (lock !== 1'b1) begin n_fail++; $display("FAIL b2b_relock: got %b want 1", lock); end
      n_checks++; if (phase_sel !== 2'd2) begin n_fail++; $display("FAIL b2b_relock_phase: got %0d want 2", phase_sel); end
   endtask

   initial begin
      test_power_on();
      test_tx_model();
      test_reset();
      test_saturate_and_tie();
      test_override();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
